// File: rtl/box_muller_radius.sv
// Box-Muller radius stage: radius = sqrt(-2 * ln_x), signed Q3.28 in, unsigned Q3.28 out.
// Restoring digit-by-digit square root, one root bit per clock, valid/ready on both sides.
// Optional macro GRNG_SQRT_ROUND_EN: one extra guard iteration and round-half-up result.
module box_muller_radius #(
    parameter int unsigned FRAC_BITS = 28,
    parameter int unsigned WIDTH     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ln_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] radius,
    output logic             domain_err
);

`ifdef GRNG_SQRT_ROUND_EN
    localparam int unsigned NumIter = 32;
`else
    localparam int unsigned NumIter = 31;
`endif
    localparam int unsigned RadW  = 2 * NumIter;  // radicand bits consumed two per step
    localparam int unsigned RemQW = NumIter + 2;  // stored partial remainder
    localparam int unsigned RemSW = RemQW + 2;    // remainder after bringing down two bits

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [RadW-1:0]    rad_q, rad_d;
    logic [RemQW-1:0]   rem_q, rem_d;
    logic [NumIter-1:0] root_q, root_d;
    logic               err_q, err_d;

    logic               accept;
    logic               ln_pos;
    logic signed [WIDTH:0] ln_ext;
    logic signed [WIDTH:0] ln_neg;
    logic [WIDTH:0]     v_op;
    logic [RadW-1:0]    rad_init;
    logic [RemSW-1:0]   rem_sh;
    logic [RemSW-1:0]   trial;
    logic               ge;

    assign accept = in_valid && in_ready;

    // Operand formation: v = -2*ln_x as unsigned Q5.28; -8.0 maps to exactly 2^32
    always_comb begin
        ln_pos = !ln_x[WIDTH-1] && (|ln_x);
        ln_ext = {ln_x[WIDTH-1], ln_x};
        ln_neg = -ln_ext;
        v_op   = ln_pos ? '0 : (ln_neg <<< 1);
        // Q5.56 radicand, left-justified so the top two bits are consumed first
        rad_init = RadW'({v_op, {FRAC_BITS{1'b0}}}) << (RadW - 62);
    end

    // One restoring square-root step: bring down two bits, trial-subtract (4*root + 1)
    always_comb begin
        rem_sh = {rem_q, rad_q[RadW-1 -: 2]};
        trial  = RemSW'({root_q, 2'b01});
        ge     = (rem_sh >= trial);
    end

    // Datapath next-state
    always_comb begin
        cnt_d  = cnt_q;
        rad_d  = rad_q;
        rem_d  = rem_q;
        root_d = root_q;
        err_d  = err_q;
        if (state_q == StIdle && accept) begin
            cnt_d  = 5'(NumIter - 1);
            rad_d  = rad_init;
            rem_d  = '0;
            root_d = '0;
            err_d  = ln_pos;
        end else if (state_q == StCalc) begin
            cnt_d  = cnt_q - 5'd1;
            rad_d  = rad_q << 2;
            rem_d  = ge ? RemQW'(rem_sh - trial) : RemQW'(rem_sh);
            root_d = {root_q[NumIter-2:0], ge};
        end
    end

    // FSM state register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            err_q   <= err_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StCalc;
            StCalc:  if (cnt_q == 5'd0) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; in_ready is masked by rst so nothing is accepted during reset
    always_comb begin
        in_ready   = (state_q == StIdle) && !rst;
        out_valid  = (state_q == StDone);
        domain_err = err_q;
    end

    // Result formatting: guard bit rounds half-up; max 4.0 keeps the add from overflowing
    always_comb begin
`ifdef GRNG_SQRT_ROUND_EN
        radius = WIDTH'({1'b0, root_q[NumIter-1:1]}) + WIDTH'(root_q[0]);
`else
        radius = WIDTH'({1'b0, root_q});
`endif
    end

endmodule

// File: tb/tb_box_muller_radius.sv
// Self-checking bench for box_muller_radius: table vectors, model-checked random vectors,
// backpressure and mid-calculation reset sequences, scoreboard on the output handshake.
module tb_box_muller_radius;

`ifdef GRNG_SQRT_ROUND_EN
    localparam int Lat = 32;
`else
    localparam int Lat = 31;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ln_x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] radius;
    logic        domain_err;

    box_muller_radius dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ln_x       (ln_x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .radius     (radius),
        .domain_err (domain_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard entries: {domain_err, radius}
    logic [32:0] sb_q[$];
    logic [32:0] mon_exp;

    typedef struct {
        logic [31:0] ln;
        logic [31:0] r;
        logic        e;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] isqrt(input logic [127:0] x);
        logic [127:0] r;
        logic [127:0] t;
        r = '0;
        for (int b = 40; b >= 0; b--) begin
            t = r | (128'd1 << b);
            if (t * t <= x) r = t;
        end
        return r;
    endfunction

    // Reference: real-valued sqrt(-2*ln) evaluated with integer square roots
    function automatic logic [32:0] model(input logic [31:0] ln);
        longint       lv;
        longint       v;
        logic [127:0] big;
        logic [127:0] r;
        if ($signed(ln) > 0) return {1'b1, 32'h0};
        lv  = longint'($signed(ln));
        v   = -2 * lv;
        big = 128'(v) << 28;
`ifdef GRNG_SQRT_ROUND_EN
        r = isqrt(big << 2);
        r = (r + 128'd1) >> 1;
`else
        r = isqrt(big);
`endif
        return {1'b0, r[31:0]};
    endfunction

    // Output monitor: one pop per handshake, sampled away from the rising edge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got radius %0h, expected no output", radius);
            end else begin
                mon_exp = sb_q.pop_front();
                check("radius", 64'(radius), 64'(mon_exp[31:0]));
                check("domain_err", 64'(domain_err), 64'(mon_exp[32]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check(name, 64'(n), 64'(Lat));
    endtask

    // Full transaction with out_ready held high
    task automatic send(input logic [31:0] ln, input logic [31:0] er, input logic ee);
        wait_ready();
        in_valid = 1'b1;
        ln_x     = ln;
        tick();
        sb_q.push_back({ee, er});
        in_valid = 1'b0;
        ln_x     = $urandom;
        wait_out("latency");
        tick();
    endtask

    vec_t        vecs[7];
    logic [31:0] held;
    logic [31:0] rln;
    logic [32:0] mexp;

    initial begin
        vecs[0] = '{ln: 32'hF800_0000, r: 32'h1000_0000, e: 1'b0};
        vecs[1] = '{ln: 32'hF000_0000, r: 32'h16A0_9E66, e: 1'b0};
        vecs[2] = '{ln: 32'h8000_0000, r: 32'h4000_0000, e: 1'b0};
        vecs[3] = '{ln: 32'hE000_0000, r: 32'h2000_0000, e: 1'b0};
        vecs[4] = '{ln: 32'h0000_0000, r: 32'h0000_0000, e: 1'b0};
        vecs[5] = '{ln: 32'h0000_0400, r: 32'h0000_0000, e: 1'b1};
        vecs[6] = '{ln: 32'hF800_0000, r: 32'h1000_0000, e: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ln_x      = '0;
        repeat (3) tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_radius", 64'(radius), 64'd0);
        check("rst_domain_err", 64'(domain_err), 64'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        foreach (vecs[i]) send(vecs[i].ln, vecs[i].r, vecs[i].e);

        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) rln = $urandom | 32'h8000_0000;
            else            rln = -($urandom_range(0, 32'h0FFF_FFFF));
            mexp = model(rln);
            send(rln, mexp[31:0], mexp[32]);
        end

        // Backpressure: result held, new input waits until after the output handshake
        out_ready = 1'b0;
        wait_ready();
        in_valid = 1'b1;
        ln_x     = 32'hF800_0000;
        tick();
        sb_q.push_back({1'b0, 32'h1000_0000});
        ln_x = 32'hE000_0000;
        wait_out("bp_latency");
        held = radius;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_radius_stable", 64'(radius), 64'(held));
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_not_yet_accepted", 64'(in_ready), 64'd1);
        tick();
        sb_q.push_back({1'b0, 32'h2000_0000});
        check("bp_accepted", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_out("bp2_latency");
        tick();

        // Reset in the middle of a calculation aborts it without producing output
        wait_ready();
        in_valid = 1'b1;
        ln_x     = 32'hF000_0000;
        tick();
        in_valid = 1'b0;
        repeat (15) tick();
        rst = 1'b1;
        tick();
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_radius", 64'(radius), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("abort_in_ready_after", 64'(in_ready), 64'd1);
        send(32'hF800_0000, 32'h1000_0000, 1'b0);

        repeat (2) tick();
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
